gshare_spec: RTL and testbench

Parametrised gshare direction predictor for the fetch stage. It uses a speculative global history register (GHR) that is updated at prediction time. Each prediction returns a history checkpoint. On a misprediction, the resolution path restores the GHR from that checkpoint. Counter width, table depth and history length are configurable, and a saturating mispredict counter provides performance monitoring.

---
 rtl/gshare_spec_pkg.sv | 20 ++
 rtl/gshare_spec_sat_counter.sv | 27 ++
 rtl/gshare_spec.sv | 116 +++++++++++
 tb/tb_gshare_spec.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/gshare_spec_pkg.sv
// gshare_spec_pkg: shared constants and types for the gshare predictor.
//   IDX_BITS_DEF / HLEN_DEF / CNT_BITS_DEF : default geometry
//   ghr_t  : global history value at the default history length
//   cnt_t  : PHT saturating counter at the default counter width
//   cnt_init() : weakly-not-taken counter value for a given width
package gshare_spec_pkg;

  localparam int IDX_BITS_DEF = 10;
  localparam int HLEN_DEF     = 10;
  localparam int CNT_BITS_DEF = 2;

  typedef logic [HLEN_DEF-1:0]     ghr_t;
  typedef logic [CNT_BITS_DEF-1:0] cnt_t;

  // Largest value whose MSB is still clear: "weakly not-taken".
  function automatic int cnt_init(input int cnt_bits);
    return (2 ** (cnt_bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/gshare_spec_sat_counter.sv
// sat_counter: combinational next-value logic for an up/down saturating
// counter. Holds at 0 when decrementing and at all-ones when incrementing.
//   cnt_i : current counter value
//   en_i  : apply a step this cycle
//   inc_i : 1 = increment, 0 = decrement
//   cnt_o : next counter value
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] cnt_i,
  input  logic         en_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (en_i) begin
      if (inc_i) begin
        if (cnt_i != {W{1'b1}}) cnt_o = cnt_i + W'(1);
      end else begin
        if (cnt_i != '0) cnt_o = cnt_i - W'(1);
      end
    end
  end

endmodule

// File: rtl/gshare_spec.sv
// gshare_spec: gshare branch direction predictor with a speculative global
// history register. Each prediction hands back the history it used as a
// checkpoint; a mispredicted resolution restores history from it.
//   clk_i, rst_n_i (async, active-low), flush_i (sync clear of all state)
//   pred_valid_i, pc_i           : prediction request (consumed this cycle)
//   pred_taken_o, pred_index_o,
//   pred_ghr_o                   : combinational prediction + checkpoint
//   res_valid_i, res_index_i,
//   res_ghr_i, res_taken_i,
//   res_mispred_i                : branch resolution / training
//   mispred_cnt_o                : saturating mispredict count
module gshare_spec
  import gshare_spec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int OFFSET    = 2,
  parameter int IDX_BITS  = IDX_BITS_DEF,
  parameter int HLEN      = HLEN_DEF,
  parameter int CNT_BITS  = CNT_BITS_DEF,
  parameter int CNT_INIT  = cnt_init(CNT_BITS),
  parameter int PERF_BITS = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 flush_i,
  input  logic                 pred_valid_i,
  input  logic [XLEN-1:0]      pc_i,
  output logic                 pred_taken_o,
  output logic [IDX_BITS-1:0]  pred_index_o,
  output logic [HLEN-1:0]      pred_ghr_o,
  input  logic                 res_valid_i,
  input  logic [IDX_BITS-1:0]  res_index_i,
  input  logic [HLEN-1:0]      res_ghr_i,
  input  logic                 res_taken_i,
  input  logic                 res_mispred_i,
  output logic [PERF_BITS-1:0] mispred_cnt_o
);

  localparam int                  DEPTH      = 2 ** IDX_BITS;
  localparam logic [CNT_BITS-1:0] CNT_INIT_V = CNT_BITS'(CNT_INIT);

  logic [HLEN-1:0]      ghr_q, ghr_d;
  logic [HLEN-1:0]      ghr_restore, ghr_spec;
  logic [CNT_BITS-1:0]  pht_q [DEPTH];
  logic [CNT_BITS-1:0]  pht_wr_cnt;
  logic [PERF_BITS-1:0] mispred_q, mispred_d;
  logic                 res_mis;
  logic                 unused_bits;

  // Only the index slice of the PC and the low HLEN-1 checkpoint bits matter.
  assign unused_bits = ^{pc_i, res_ghr_i};

  assign res_mis = res_valid_i & res_mispred_i;

  // Prediction path: registered state only, no bypass of this cycle's update.
  assign pred_index_o = pc_i[IDX_BITS+OFFSET-1:OFFSET] ^ IDX_BITS'(ghr_q);
  assign pred_taken_o = pht_q[pred_index_o][CNT_BITS-1];
  assign pred_ghr_o   = ghr_q;

  generate
    if (HLEN == 1) begin : g_hist_one
      assign ghr_restore = res_taken_i;
      assign ghr_spec    = pred_taken_o;
    end else begin : g_hist_wide
      assign ghr_restore = {res_ghr_i[HLEN-2:0], res_taken_i};
      assign ghr_spec    = {ghr_q[HLEN-2:0], pred_taken_o};
    end
  endgenerate

  // A mispredict wins over a same-cycle fetch, which is on the wrong path.
  always_comb begin
    ghr_d = ghr_q;
    if (res_mis)           ghr_d = ghr_restore;
    else if (pred_valid_i) ghr_d = ghr_spec;
  end

  sat_counter #(.W(CNT_BITS)) u_pht_sat (
    .cnt_i (pht_q[res_index_i]),
    .en_i  (res_valid_i),
    .inc_i (res_taken_i),
    .cnt_o (pht_wr_cnt)
  );

  sat_counter #(.W(PERF_BITS)) u_perf_sat (
    .cnt_i (mispred_q),
    .en_i  (res_mis),
    .inc_i (1'b1),
    .cnt_o (mispred_d)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ghr_q     <= '0;
      mispred_q <= '0;
    end else if (flush_i) begin
      ghr_q     <= '0;
      mispred_q <= '0;
    end else begin
      ghr_q     <= ghr_d;
      mispred_q <= mispred_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) pht_q[i] <= CNT_INIT_V;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) pht_q[i] <= CNT_INIT_V;
    end else if (res_valid_i) begin
      pht_q[res_index_i] <= pht_wr_cnt;
    end
  end

  assign mispred_cnt_o = mispred_q;

endmodule

// File: tb/tb_gshare_spec.sv
module tb_gshare_spec;
  import gshare_spec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        pred_valid = 1'b0;
  logic [31:0] pc = '0;
  logic        res_valid = 1'b0;
  logic [9:0]  res_index = '0;
  ghr_t        res_ghr = '0;
  logic        res_taken = 1'b0;
  logic        res_mispred = 1'b0;

  logic        taken_a, taken_b;
  logic [9:0]  idx_a, idx_b;
  ghr_t        ghr_a, ghr_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  gshare_spec dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .pred_valid_i(pred_valid), .pc_i(pc),
    .pred_taken_o(taken_a), .pred_index_o(idx_a), .pred_ghr_o(ghr_a),
    .res_valid_i(res_valid), .res_index_i(res_index), .res_ghr_i(res_ghr),
    .res_taken_i(res_taken), .res_mispred_i(res_mispred),
    .mispred_cnt_o(cnt_a)
  );

  gshare_spec #(.PERF_BITS(2)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
    .pred_valid_i(pred_valid), .pc_i(pc),
    .pred_taken_o(taken_b), .pred_index_o(idx_b), .pred_ghr_o(ghr_b),
    .res_valid_i(res_valid), .res_index_i(res_index), .res_ghr_i(res_ghr),
    .res_taken_i(res_taken), .res_mispred_i(res_mispred),
    .mispred_cnt_o(cnt_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: plain integers, table of counters 0..3, history as int.
  int m_pht [1024];
  int m_ghr;
  int m_cnt;

  function automatic void m_clear();
    for (int i = 0; i < 1024; i++) m_pht[i] = 1;
    m_ghr = 0;
    m_cnt = 0;
  endfunction

  initial begin
    int e_idx, e_tk;
    m_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) m_clear();
      e_idx = int'((pc >> 2) & 32'h3FF) ^ m_ghr;
      e_tk  = (m_pht[e_idx] >= 2) ? 1 : 0;
      check("m_index_a", 32'(idx_a), 32'(e_idx));
      check("m_taken_a", 32'(taken_a), 32'(e_tk));
      check("m_ghr_a", 32'(ghr_a), 32'(m_ghr));
      check("m_cnt_a", 32'(cnt_a), 32'((m_cnt > 65535) ? 65535 : m_cnt));
      check("m_taken_b", 32'(taken_b), 32'(e_tk));
      check("m_cnt_b", 32'(cnt_b), 32'((m_cnt > 3) ? 3 : m_cnt));
      if (rst_n) begin
        if (flush) begin
          m_clear();
        end else begin
          if (res_valid && res_mispred)
            m_ghr = ((int'(res_ghr) * 2) + int'(res_taken)) % 1024;
          else if (pred_valid)
            m_ghr = ((m_ghr * 2) + e_tk) % 1024;
          if (res_valid) begin
            if (res_taken) m_pht[res_index] = (m_pht[res_index] == 3) ? 3 : m_pht[res_index] + 1;
            else           m_pht[res_index] = (m_pht[res_index] == 0) ? 0 : m_pht[res_index] - 1;
          end
          if (res_valid && res_mispred) m_cnt++;
        end
      end
    end
  end

  // One transaction per cycle: drive after the edge, return at the negedge.
  task automatic cyc(input logic pv, input logic [31:0] pcv, input logic rv,
                     input logic [9:0] ri, input logic rt, input logic rm,
                     input logic [9:0] rg, input logic fl);
    @(posedge clk);
    #1;
    pred_valid = pv; pc = pcv; res_valid = rv; res_index = ri;
    res_taken = rt; res_mispred = rm; res_ghr = rg; flush = fl;
    @(negedge clk);
    $display("cyc pv=%0d pc=%08h rv=%0d ri=%03h rt=%0d rm=%0d rg=%03h fl=%0d -> idx=%03h tk=%0d ghr=%03h cnt=%0d",
             pv, pcv, rv, ri, rt, rm, rg, fl, idx_a, taken_a, ghr_a, cnt_a);
  endtask

  task automatic rand_cyc();
    logic [31:0] pcv;
    logic [9:0]  ri;
    pcv = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2);
    ri  = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, 15)) : 10'($urandom);
    cyc(1'($urandom), pcv, 1'($urandom), ri, 1'($urandom), 1'($urandom),
        10'($urandom), ($urandom_range(0, 99) == 0));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_ghr", 32'(ghr_a), 32'h0);
    check("rst_cnt", 32'(cnt_a), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // First prediction after reset.
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    check("first_index", 32'(idx_a), 32'h040);
    check("first_taken", 32'(taken_a), 32'h0);
    check("first_ghr", 32'(ghr_a), 32'h0);

    // Train 0x040 up to saturation; each check sees the previous cycle's update.
    cyc(0, 32'h100, 1, 10'h040, 1, 0, 0, 0);
    check("ghr_after_nt_pred", 32'(ghr_a), 32'h0);
    check("train1_sameconcycle", 32'(taken_a), 32'h0);
    cyc(0, 32'h100, 1, 10'h040, 1, 0, 0, 0);
    check("train_cnt2", 32'(taken_a), 32'h1);
    cyc(0, 32'h100, 1, 10'h040, 1, 0, 0, 0);
    check("train_cnt3", 32'(taken_a), 32'h1);
    cyc(0, 32'h100, 1, 10'h040, 0, 0, 0, 0);
    check("train_sat3", 32'(taken_a), 32'h1);
    cyc(0, 32'h100, 1, 10'h040, 0, 0, 0, 0);
    check("dec_to2", 32'(taken_a), 32'h1);
    cyc(0, 32'h100, 0, 0, 0, 0, 0, 0);
    check("dec_to1", 32'(taken_a), 32'h0);

    // Make indices 0x40,0x41,0x43,0x47 strongly taken.
    for (int k = 0; k < 2; k++) begin
      cyc(0, 32'h100, 1, 10'h040, 1, 0, 0, 0);
      cyc(0, 32'h100, 1, 10'h041, 1, 0, 0, 0);
      cyc(0, 32'h100, 1, 10'h043, 1, 0, 0, 0);
      cyc(0, 32'h100, 1, 10'h047, 1, 0, 0, 0);
    end
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    check("spec1_idx", 32'(idx_a), 32'h040);
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    check("spec2_idx", 32'(idx_a), 32'h041);
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    check("spec3_idx", 32'(idx_a), 32'h043);
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    check("spec4_idx", 32'(idx_a), 32'h047);
    check("spec4_taken", 32'(taken_a), 32'h1);
    cyc(0, 32'h100, 1, 10'h3FF, 0, 1, 10'h005, 0);
    check("ghr_1111", 32'(ghr_a), 32'h00F);
    cyc(0, 32'h100, 0, 0, 0, 0, 0, 0);
    check("ghr_restored", 32'(ghr_a), 32'h00A);
    check("mispred_1", 32'(cnt_a), 32'h1);

    // Mispredict with a same-cycle fetch: only the restore counts.
    cyc(1, 32'h100, 1, 10'h3FF, 1, 1, 10'h003, 0);
    cyc(0, 32'h200, 0, 0, 0, 0, 0, 0);
    check("ghr_drop_spec", 32'(ghr_a), 32'h007);
    check("mispred_2", 32'(cnt_a), 32'h2);

    // Same-index prediction and update: old value now, new value next cycle.
    cyc(0, 32'h200, 1, 10'h087, 1, 0, 0, 0);
    check("same_idx_old", 32'(taken_a), 32'h0);
    cyc(0, 32'h200, 0, 0, 0, 0, 0, 0);
    check("same_idx_new", 32'(taken_a), 32'h1);

    // Flush beats a same-cycle resolution.
    cyc(0, 32'h200, 1, 10'h087, 1, 1, 10'h3FF, 1);
    cyc(0, 32'h21C, 0, 0, 0, 0, 0, 0);
    check("flush_ghr", 32'(ghr_a), 32'h0);
    check("flush_cnt", 32'(cnt_a), 32'h0);
    check("flush_idx", 32'(idx_a), 32'h087);
    check("flush_taken87", 32'(taken_a), 32'h0);
    cyc(0, 32'h100, 0, 0, 0, 0, 0, 0);
    check("flush_taken40", 32'(taken_a), 32'h0);

    // Five mispredicts: 16-bit counter reads 5, 2-bit counter saturates at 3.
    for (int k = 0; k < 5; k++) cyc(0, 32'h0, 1, 10'h3FF, 0, 1, 10'h000, 0);
    cyc(0, 32'h0, 0, 0, 0, 0, 0, 0);
    check("perf16_5", 32'(cnt_a), 32'h5);
    check("perf2_sat", 32'(cnt_b), 32'h3);

    for (int k = 0; k < 1500; k++) rand_cyc();

    // Asynchronous reset mid-run clears everything at once.
    @(posedge clk);
    #1;
    pred_valid = 1'b0; res_valid = 1'b0; flush = 1'b0; pc = 32'h100;
    rst_n = 1'b0;
    #2;
    check("async_ghr", 32'(ghr_a), 32'h0);
    check("async_cnt", 32'(cnt_a), 32'h0);
    check("async_taken", 32'(taken_a), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int k = 0; k < 300; k++) rand_cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
